// File: rtl/serial_subtractor.sv
// Bit-serial N-bit subtractor: diff = a - b - bin, LSB first, one bit/clk.
// Optional signed-overflow output enabled by defining SERIAL_SUB_OVF_EN.
module serial_subtractor #(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] diff,
  output logic         bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic         ovf
`endif
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t         state_q;
  logic [N-1:0]   a_q;
  logic [N-1:0]   b_q;
  logic           borrow_q;
  logic [CW-1:0]  cnt_q;
  logic [N-1:0]   res_q;
  logic           busy_q;
  logic           done_q;
  logic [N-1:0]   diff_q;
  logic           bout_q;
`ifdef SERIAL_SUB_OVF_EN
  logic           ovf_q;
`endif

  logic           bit_d;
  logic           borrow_d;
  logic [N-1:0]   res_d;
  logic           last;
  logic           accept;

  // Full-subtractor cell on the current LSB of the shifting operands.
  always_comb begin
    bit_d    = a_q[0] ^ b_q[0] ^ borrow_q;
    borrow_d = (~a_q[0] & b_q[0]) |
               (~(a_q[0] ^ b_q[0]) & borrow_q);
    res_d    = {bit_d, res_q[N-1:1]};
    last     = (cnt_q == LAST);
    accept   = start && (state_q != S_RUN);
  end

  // Control FSM plus datapath; all outputs are registered here.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      cnt_q    <= '0;
      res_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          if (accept) begin
            state_q  <= S_RUN;
            a_q      <= a;
            b_q      <= b;
            borrow_q <= bin;
            cnt_q    <= '0;
            res_q    <= '0;
            busy_q   <= 1'b1;
          end else begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
          end
        end
        S_RUN: begin
          a_q      <= a_q >> 1;
          b_q      <= b_q >> 1;
          borrow_q <= borrow_d;
          res_q    <= res_d;
          cnt_q    <= cnt_q + 1'b1;
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            diff_q  <= res_d;
            bout_q  <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            // Borrow into MSB vs borrow out of MSB.
            ovf_q   <= borrow_q ^ borrow_d;
`endif
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign diff = diff_q;
  assign bout = bout_q;
`ifdef SERIAL_SUB_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed self-checking bench for serial_subtractor (N=8 and N=3).
// Build with SERIAL_SUB_OVF_EN to exercise the overflow output.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       start8;
  logic [7:0] a8, b8;
  logic       bin8;
  logic       busy8, done8;
  logic [7:0] diff8;
  logic       bout8;

  logic       start3;
  logic [2:0] a3, b3;
  logic       bin3;
  logic       busy3, done3;
  logic [2:0] diff3;
  logic       bout3;

`ifdef SERIAL_SUB_OVF_EN
  logic ovf8, ovf3;
`endif

  int tests = 0;
  int fails = 0;

  serial_subtractor #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8),
    .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8),
    .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.N(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .a(a3), .b(b3), .bin(bin3),
    .busy(busy3), .done(done3),
    .diff(diff3), .bout(bout3)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf3)
`endif
  );

  task automatic op8(input logic [7:0] a, input logic [7:0] b,
                     input logic bi, output int lat, output int bc);
    a8 = a; b8 = b; bin8 = bi; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 0; bc = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      if (busy8 === 1'b1) bc++;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic op3(input logic [2:0] a, input logic [2:0] b,
                     input logic bi, output int lat);
    a3 = a; b3 = b; bin3 = bi; start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    lat = 0;
    while (done3 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      $display("FAIL reset8: got busy=%b done=%b diff=%h bout=%b want 0",
               busy8, done8, diff8, bout8);
      fails++;
    end
    tests++;
    if ({busy3, done3, diff3, bout3} !== 6'd0) begin
      $display("FAIL reset3: got busy=%b done=%b diff=%h bout=%b want 0",
               busy3, done3, diff3, bout3);
      fails++;
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_basic;
    int lat, bc;
    op8(8'h05, 8'h03, 1'b0, lat, bc);
    tests++;
    if (lat !== 8 || bc !== 8) begin
      $display("FAIL basic_timing: got lat=%0d busy=%0d want 8/8", lat, bc);
      fails++;
    end
    tests++;
    if (diff8 !== 8'h02 || bout8 !== 1'b0) begin
      $display("FAIL basic_result: got %h/%b want 02/0", diff8, bout8);
      fails++;
    end
    @(posedge clk); #1;
    tests++;
    if (done8 !== 1'b0 || diff8 !== 8'h02) begin
      $display("FAIL basic_pulse: got done=%b diff=%h want 0/02",
               done8, diff8);
      fails++;
    end
  endtask

  task automatic test_borrow;
    int lat, bc;
    op8(8'h03, 8'h05, 1'b0, lat, bc);
    tests++;
    if (diff8 !== 8'hFE || bout8 !== 1'b1 || lat !== 8) begin
      $display("FAIL borrow_neg: got %h/%b lat=%0d want FE/1 lat=8",
               diff8, bout8, lat);
      fails++;
    end
    op8(8'h00, 8'h00, 1'b1, lat, bc);
    tests++;
    if (diff8 !== 8'hFF || bout8 !== 1'b1) begin
      $display("FAIL borrow_bin: got %h/%b want FF/1", diff8, bout8);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_ignore;
    int lat;
    a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; bin8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; bin8 = 1'b0;
    lat = 3;
    while (done8 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== 8 || diff8 !== 8'h0F || bout8 !== 1'b0) begin
      $display("FAIL ignore: got lat=%0d diff=%h bout=%b want 8/0F/0",
               lat, diff8, bout8);
      fails++;
    end
    @(posedge clk); #1;
    tests++;
    if (done8 !== 1'b0 || busy8 !== 1'b0) begin
      $display("FAIL ignore_idle: got done=%b busy=%b want 0/0",
               done8, busy8);
      fails++;
    end
  endtask

  task automatic test_back_to_back;
    int lat, lat2;
    a8 = 8'h20; b8 = 8'h01; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    lat = 0;
    while (done8 !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (lat !== 8 || diff8 !== 8'h1F) begin
      $display("FAIL b2b_first: got lat=%0d diff=%h want 8/1F", lat, diff8);
      fails++;
    end
    a8 = 8'h40; b8 = 8'h02;
    @(posedge clk); #1;
    tests++;
    if (busy8 !== 1'b1 || done8 !== 1'b0 || diff8 !== 8'h1F) begin
      $display("FAIL b2b_accept: got busy=%b done=%b diff=%h want 1/0/1F",
               busy8, done8, diff8);
      fails++;
    end
    a8 = 8'h00; b8 = 8'h00;
    lat2 = 1;
    while (done8 !== 1'b1 && lat2 < 20) begin
      @(posedge clk); #1;
      lat2++;
    end
    start8 = 1'b0;
    tests++;
    if (lat2 !== 9 || diff8 !== 8'h3E || bout8 !== 1'b0) begin
      $display("FAIL b2b_second: got gap=%0d diff=%h bout=%b want 9/3E/0",
               lat2, diff8, bout8);
      fails++;
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int nd, lat, bc;
    a8 = 8'h55; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if ({busy8, done8, diff8, bout8} !== 11'd0) begin
      $display("FAIL reset_mid: got busy=%b done=%b diff=%h bout=%b want 0",
               busy8, done8, diff8, bout8);
      fails++;
    end
    nd = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) nd++;
    end
    tests++;
    if (nd !== 0) begin
      $display("FAIL reset_nodone: got %0d done pulses want 0", nd);
      fails++;
    end
    op8(8'h09, 8'h04, 1'b0, lat, bc);
    tests++;
    if (diff8 !== 8'h05 || bout8 !== 1'b0 || lat !== 8) begin
      $display("FAIL reset_after: got %h/%b lat=%0d want 05/0 lat=8",
               diff8, bout8, lat);
      fails++;
    end
    @(posedge clk); #1;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf;
    int lat, bc;
    op8(8'h80, 8'h01, 1'b0, lat, bc);
    tests++;
    if (diff8 !== 8'h7F || bout8 !== 1'b0 || ovf8 !== 1'b1) begin
      $display("FAIL ovf_a: got %h/%b/%b want 7F/0/1", diff8, bout8, ovf8);
      fails++;
    end
    op8(8'h7F, 8'hFF, 1'b0, lat, bc);
    tests++;
    if (diff8 !== 8'h80 || bout8 !== 1'b1 || ovf8 !== 1'b1) begin
      $display("FAIL ovf_b: got %h/%b/%b want 80/1/1", diff8, bout8, ovf8);
      fails++;
    end
    op8(8'h05, 8'h03, 1'b0, lat, bc);
    tests++;
    if (diff8 !== 8'h02 || ovf8 !== 1'b0) begin
      $display("FAIL ovf_c: got %h/%b want 02/0", diff8, ovf8);
      fails++;
    end
    @(posedge clk); #1;
  endtask
`endif

  task automatic test_exhaustive3;
    int lat;
    logic [3:0] exp;
    for (int ai = 0; ai < 8; ai++) begin
      for (int bi = 0; bi < 8; bi++) begin
        for (int ci = 0; ci < 2; ci++) begin
          exp = 4'(ai - bi - ci);
          op3(3'(ai), 3'(bi), ci[0], lat);
          tests++;
          if ({bout3, diff3} !== exp || lat !== 3) begin
            $display("FAIL exh3 a=%0d b=%0d bin=%0d: got %h lat=%0d want %h lat=3",
                     ai, bi, ci, {bout3, diff3}, lat, exp);
            fails++;
          end
        end
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start3 = 1'b0; a3 = '0; b3 = '0; bin3 = 1'b0;
    test_reset();
    test_basic();
    test_borrow();
    test_ignore();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    test_exhaustive3();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
